stopwatch_button_ctrl: RTL and testbench

Conditions the raw Start/Stop push-button of the stopwatch and produces the run/stop level and clear pulse consumed by the stopwatch top-level and its `timer`. The raw pin is synchronised, debounced, and classified by a press FSM:
- a short press toggles the run level;
- a long press issues a one-cycle clear and forces stop.

The block sits directly upstream of the timer's start/stop input and runs in the 100 MHz system clock domain.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/btn_synchronizer.sv | 27 ++
 rtl/stopwatch_button_ctrl.sv | 159 +++++++++++++++
 tb/tb_stopwatch_button_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch button path.
// Holds the press FSM state encoding and the milliseconds-to-cycles conversion.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } btn_state_t;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_synchronizer.sv
// Two-flop synchroniser for a raw push-button pin.
// The output is normalised so that 1 always means pressed.
module btn_synchronizer #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_btn
);

    localparam logic RELEASED_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0] r_sync;

    // Shift the raw pin through two flops; reset to the released pin level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {RELEASED_LVL, RELEASED_LVL};
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    assign o_btn = ACTIVE_LOW ? ~r_sync[1] : r_sync[1];

endmodule

// File: rtl/stopwatch_button_ctrl.sv
// Start/Stop button conditioning: synchronise, debounce, classify short/long press.
// Short press toggles the run level; long press pulses clear and forces stop.
module stopwatch_button_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ       = 100000000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_PRESS_MS  = 2000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_startStop,
    output logic o_clear,
    output logic o_pressPulse,
    output logic o_btnState
);

    localparam int DEB_CYCLES  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int LONG_CYCLES = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
    localparam int CW          = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    logic          w_btn;
    btn_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_held;
    logic [CW-1:0] r_hold, w_hold_nxt;
    logic          r_long_flag, w_long_nxt;
    logic          r_start_stop, w_ss_nxt;
    logic          r_clear, w_clear_nxt;
    logic          r_press_pulse, w_pulse_nxt;
    logic          r_btn_state, w_btn_state_nxt;
    logic          w_long_hit;

    btn_synchronizer #(
        .ACTIVE_LOW (BTN_ACTIVE_LOW != 0)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_btn (i_btn),
        .o_btn (w_btn)
    );

    assign w_long_hit = !r_long_flag && (r_cnt == LONG_LAST);

    // Next-state, counter and output decisions for the press FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cnt_held      = r_cnt;
        w_hold_nxt      = r_hold;
        w_long_nxt      = r_long_flag;
        w_ss_nxt        = r_start_stop;
        w_clear_nxt     = 1'b0;
        w_pulse_nxt     = 1'b0;
        w_btn_state_nxt = r_btn_state;
        case (r_state)
            IDLE: begin
                if (w_btn) begin
                    w_state_nxt = DEB_PRESS;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            DEB_PRESS: begin
                if (!w_btn) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt >= DEB_LAST) begin
                    w_state_nxt     = HELD;
                    w_cnt_nxt       = CNT_ZERO;
                    w_pulse_nxt     = 1'b1;
                    w_btn_state_nxt = 1'b1;
                    w_long_nxt      = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                // Long detection wins over a same-cycle release so clear is never lost.
                if (w_long_hit) begin
                    w_cnt_held  = LONG_MAX;
                    w_clear_nxt = 1'b1;
                    w_ss_nxt    = 1'b0;
                    w_long_nxt  = 1'b1;
                end else if (r_long_flag) begin
                    w_cnt_held = r_cnt;
                end else begin
                    w_cnt_held = r_cnt + CNT_ONE;
                end
                if (!w_btn) begin
                    w_state_nxt = DEB_REL;
                    w_hold_nxt  = w_cnt_held;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt = w_cnt_held;
                end
            end
            DEB_REL: begin
                if (w_btn) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = r_hold;
                end else if (r_cnt >= DEB_LAST) begin
                    w_state_nxt     = IDLE;
                    w_cnt_nxt       = CNT_ZERO;
                    w_btn_state_nxt = 1'b0;
                    if (!r_long_flag) begin
                        w_ss_nxt = ~r_start_stop;
                    end else begin
                        w_ss_nxt = r_start_stop;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= CNT_ZERO;
            r_hold        <= CNT_ZERO;
            r_long_flag   <= 1'b0;
            r_start_stop  <= 1'b0;
            r_clear       <= 1'b0;
            r_press_pulse <= 1'b0;
            r_btn_state   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_hold        <= w_hold_nxt;
            r_long_flag   <= w_long_nxt;
            r_start_stop  <= w_ss_nxt;
            r_clear       <= w_clear_nxt;
            r_press_pulse <= w_pulse_nxt;
            r_btn_state   <= w_btn_state_nxt;
        end
    end

    assign o_startStop  = r_start_stop;
    assign o_clear      = r_clear;
    assign o_pressPulse = r_press_pulse;
    assign o_btnState   = r_btn_state;

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Directed self-checking bench for stopwatch_button_ctrl with scaled-down timing
// (debounce 4 cycles, long press 20 cycles).
module tb_stopwatch_button_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic o_start_stop, o_clear, o_press_pulse, o_btn_state;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int pulse_cnt = 0, last_pulse = -1;
    int clear_cnt = 0, last_clear = -1;
    int ss_chg = 0, last_ss = -1;
    int viol = 0;
    logic prev_pulse = 1'b0, prev_clear = 1'b0, prev_ss = 1'b0;

    stopwatch_button_ctrl #(
        .CLK_FREQ       (1000),
        .DEBOUNCE_MS    (4),
        .LONG_PRESS_MS  (20),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn        (btn),
        .o_startStop  (o_start_stop),
        .o_clear      (o_clear),
        .o_pressPulse (o_press_pulse),
        .o_btnState   (o_btn_state)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp output events.
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: record output pulses/toggles and pulse-rule violations.
    always @(negedge clk) begin
        if (o_press_pulse) begin
            pulse_cnt  <= pulse_cnt + 1;
            last_pulse <= cyc;
        end
        if (o_clear) begin
            clear_cnt  <= clear_cnt + 1;
            last_clear <= cyc;
        end
        if ((o_press_pulse && prev_pulse) || (o_clear && prev_clear) || (o_clear && o_press_pulse))
            viol <= viol + 1;
        if (o_start_stop !== prev_ss) begin
            ss_chg  <= ss_chg + 1;
            last_ss <= cyc;
        end
        prev_pulse <= o_press_pulse;
        prev_clear <= o_clear;
        prev_ss    <= o_start_stop;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0, t_rel, pc, sc, cc;

    initial begin
        // Reset
        btn = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_eq("rst_ss",    o_start_stop,  0);
        check_eq("rst_clear", o_clear,       0);
        check_eq("rst_pulse", o_press_pulse, 0);
        check_eq("rst_btn",   o_btn_state,   0);
        step(5);

        // 1. Clean short press, twice
        for (int k = 0; k < 2; k++) begin
            pc = pulse_cnt;
            btn = 1'b0; t0 = cyc;
            step(10);
            check_eq("p1_btnstate", o_btn_state, 1);
            check_eq("p1_pulse_cnt", pulse_cnt - pc, 1);
            check_eq("p1_pulse_lat", last_pulse - t0, 6);
            btn = 1'b1; t_rel = cyc;
            step(10);
            check_eq("p1_ss", o_start_stop, (k == 0) ? 1 : 0);
            check_eq("p1_toggle_lat", last_ss - t_rel, 6);
            check_eq("p1_btnstate_rel", o_btn_state, 0);
        end

        // 2. Bouncy press
        pc = pulse_cnt;
        for (int k = 0; k < 6; k++) begin
            btn = (k % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        btn = 1'b0; t0 = cyc;
        step(10);
        check_eq("p2_pulse_cnt", pulse_cnt - pc, 1);
        check_eq("p2_pulse_lat", last_pulse - t0, 6);
        btn = 1'b1;
        step(10);
        check_eq("p2_ss", o_start_stop, 1);

        // 3. Long press starting from run
        pc = pulse_cnt; cc = clear_cnt; sc = ss_chg;
        btn = 1'b0; t0 = cyc;
        step(40);
        check_eq("p3_pulse_lat", last_pulse - t0, 6);
        check_eq("p3_pulse_cnt", pulse_cnt - pc, 1);
        check_eq("p3_clear_cnt", clear_cnt - cc, 1);
        check_eq("p3_clear_lat", last_clear - last_pulse, 20);
        check_eq("p3_ss_held", o_start_stop, 0);
        check_eq("p3_ss_when", last_ss, last_clear);
        check_eq("p3_btnstate", o_btn_state, 1);
        sc = ss_chg;
        btn = 1'b1;
        step(10);
        check_eq("p3_no_toggle", ss_chg - sc, 0);
        check_eq("p3_ss_rel", o_start_stop, 0);
        check_eq("p3_btnstate_rel", o_btn_state, 0);
        check_eq("p3_clear_once", clear_cnt - cc, 1);

        // 4. Release bounce during HELD
        pc = pulse_cnt; sc = ss_chg;
        btn = 1'b0;
        step(8);
        btn = 1'b1;
        step(2);
        btn = 1'b0;
        step(8);
        check_eq("p4_pulse_cnt", pulse_cnt - pc, 1);
        check_eq("p4_no_toggle", ss_chg - sc, 0);
        check_eq("p4_btnstate", o_btn_state, 1);
        btn = 1'b1; t_rel = cyc;
        step(10);
        check_eq("p4_ss_rel", o_start_stop, 1);
        check_eq("p4_toggle_lat", last_ss - t_rel, 6);

        // 5. Reset mid-press
        btn = 1'b0; t0 = cyc;
        step(9);
        check_eq("p5_accepted", last_pulse - t0, 6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        t_rel = cyc;
        check_eq("p5_rst_ss",    o_start_stop,  0);
        check_eq("p5_rst_clear", o_clear,       0);
        check_eq("p5_rst_pulse", o_press_pulse, 0);
        check_eq("p5_rst_btn",   o_btn_state,   0);
        pc = pulse_cnt;
        step(10);
        check_eq("p5_pulse_cnt", pulse_cnt - pc, 1);
        check_eq("p5_pulse_lat", last_pulse - t_rel, 6);
        check_eq("p5_btnstate", o_btn_state, 1);
        btn = 1'b1;
        step(10);
        check_eq("p5_ss_rel", o_start_stop, 1);

        check_eq("pulse_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
